rx_cmd_parser: RTL and testbench

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

---
 rtl/rx_cmd_pkg.sv | 47 ++++
 rtl/rx_dec_accum.sv | 34 +++
 rtl/rx_cmd_parser.sv | 173 +++++++++++++++++
 tb/tb_rx_cmd_parser.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_cmd_pkg.sv
// Shared constants, keyword tables and state encodings for the UART command line parser.
package rx_cmd_pkg;

    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;

    localparam logic [9:0] RATE_MAX = 10'd255;

    // Keywords are left-aligned in 40 bits so one shift extracts any character.
    localparam logic [39:0] KW_INIT_S  = {"init", 8'h00};
    localparam logic [39:0] KW_NORM_S  = {"norm", 8'h00};
    localparam logic [39:0] KW_START_S = "start";
    localparam logic [39:0] KW_RATE_S  = {"rate", COLON};

    localparam logic [2:0] KW_INIT_LEN  = 3'd4;
    localparam logic [2:0] KW_NORM_LEN  = 3'd4;
    localparam logic [2:0] KW_START_LEN = 3'd5;
    localparam logic [2:0] KW_RATE_LEN  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_KEY, S_DIGIT, S_SKIP} state_e;
    typedef enum logic [1:0] {KW_INIT, KW_NORM, KW_START, KW_RATE} kw_e;

    function automatic logic [7:0] kw_char(input kw_e kw, input logic [2:0] idx);
        logic [39:0] s;
        case (kw)
            KW_INIT:  s = KW_INIT_S;
            KW_NORM:  s = KW_NORM_S;
            KW_START: s = KW_START_S;
            default:  s = KW_RATE_S;
        endcase
        s = s << (8 * idx);
        return s[39:32];
    endfunction

    function automatic logic [2:0] kw_len(input kw_e kw);
        case (kw)
            KW_INIT:  return KW_INIT_LEN;
            KW_NORM:  return KW_NORM_LEN;
            KW_START: return KW_START_LEN;
            default:  return KW_RATE_LEN;
        endcase
    endfunction

endpackage

// File: rtl/rx_dec_accum.sv
// Decimal accumulator for the rate argument; ovf_o flags that the pending digit would exceed RATE_MAX.
module rx_dec_accum
    import rx_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       dig_vld_i,
    input  logic [3:0] dig_i,
    output logic [7:0] value_o,
    output logic       ovf_o
);

    logic [9:0] acc_q;
    logic [9:0] acc_d;

    always_comb begin
        acc_d = acc_q * 10'd10 + {6'd0, dig_i};
    end

    assign ovf_o   = (acc_d > RATE_MAX);
    assign value_o = acc_q[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (dig_vld_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rx_cmd_parser.sv
// Line parser for "init", "norm", "start" and "rate:<d>" commands from a UART byte stream.
// Optional byte echo outputs are built when RX_CMD_ECHO_EN is defined.
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int MAX_LINE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iRX_DATA,
    input  logic       iRX_VALID,
    output logic       oCMD_INITIAL,
    output logic       oCMD_NORMAL,
    output logic       oCMD_START_CONTROL,
    output logic [7:0] oRATE,
    output logic       oRATE_VALID,
    output logic       oCMD_ERR
`ifdef RX_CMD_ECHO_EN
    ,
    output logic [7:0] oECHO_DATA,
    output logic       oECHO_VALID
`endif
);

    localparam int CW = $clog2(MAX_LINE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LINE);

    state_e        state_q;
    kw_e           kw_q;
    logic [2:0]    idx_q;
    logic [1:0]    ndig_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    rate_q;
    logic          init_q, norm_q, start_q, rvld_q, err_q;

    logic       vld, is_lf, is_dig, too_long;
    logic       acc_clr, acc_dig, acc_ovf;
    logic [7:0] acc_val;

    // Carriage returns are invisible to parsing and line length.
    assign vld      = iRX_VALID && (iRX_DATA != CR);
    assign is_lf    = (iRX_DATA == LF);
    assign is_dig   = (iRX_DATA >= ZERO) && (iRX_DATA <= NINE);
    assign too_long = !is_lf && (cnt_q == CNT_MAX);
    assign acc_clr  = vld && (state_q == S_IDLE);
    assign acc_dig  = vld && (state_q == S_DIGIT) && is_dig;

    rx_dec_accum u_accum (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (acc_clr),
        .dig_vld_i (acc_dig),
        .dig_i     (iRX_DATA[3:0]),
        .value_o   (acc_val),
        .ovf_o     (acc_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            kw_q    <= KW_INIT;
            idx_q   <= '0;
            ndig_q  <= '0;
            cnt_q   <= '0;
            rate_q  <= '0;
            init_q  <= 1'b0;
            norm_q  <= 1'b0;
            start_q <= 1'b0;
            rvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            init_q  <= 1'b0;
            norm_q  <= 1'b0;
            start_q <= 1'b0;
            rvld_q  <= 1'b0;
            err_q   <= 1'b0;
            if (vld) begin
                cnt_q <= is_lf ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
                case (state_q)
                    S_IDLE: begin
                        idx_q   <= 3'd1;
                        state_q <= S_KEY;
                        case (iRX_DATA)
                            "i":     kw_q <= KW_INIT;
                            "n":     kw_q <= KW_NORM;
                            "s":     kw_q <= KW_START;
                            "r":     kw_q <= KW_RATE;
                            LF:      state_q <= S_IDLE;
                            default: begin
                                state_q <= S_SKIP;
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                    S_KEY: begin
                        if (is_lf) begin
                            state_q <= S_IDLE;
                            if (idx_q == kw_len(kw_q)) begin
                                case (kw_q)
                                    KW_INIT:  init_q  <= 1'b1;
                                    KW_NORM:  norm_q  <= 1'b1;
                                    KW_START: start_q <= 1'b1;
                                    default:  err_q   <= 1'b1;
                                endcase
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (too_long || (idx_q == kw_len(kw_q)) ||
                                     (iRX_DATA != kw_char(kw_q, idx_q))) begin
                            state_q <= S_SKIP;
                            err_q   <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            if (kw_q == KW_RATE && idx_q == kw_len(kw_q) - 3'd1) begin
                                state_q <= S_DIGIT;
                                ndig_q  <= '0;
                            end
                        end
                    end
                    S_DIGIT: begin
                        if (is_lf) begin
                            state_q <= S_IDLE;
                            if (ndig_q != 2'd0) begin
                                rate_q <= acc_val;
                                rvld_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (too_long || !is_dig || (ndig_q == 2'd3) || acc_ovf) begin
                            state_q <= S_SKIP;
                            err_q   <= 1'b1;
                        end else begin
                            ndig_q <= ndig_q + 2'd1;
                        end
                    end
                    default: begin
                        if (is_lf) begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign oCMD_INITIAL       = init_q;
    assign oCMD_NORMAL        = norm_q;
    assign oCMD_START_CONTROL = start_q;
    assign oRATE              = rate_q;
    assign oRATE_VALID        = rvld_q;
    assign oCMD_ERR           = err_q;

`ifdef RX_CMD_ECHO_EN
    logic [7:0] echo_data_q;
    logic       echo_vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_data_q <= 8'hFF;
            echo_vld_q  <= 1'b0;
        end else begin
            echo_vld_q <= iRX_VALID;
            if (iRX_VALID) begin
                echo_data_q <= iRX_DATA;
            end
        end
    end

    assign oECHO_DATA  = echo_data_q;
    assign oECHO_VALID = echo_vld_q;
`endif

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Bench for rx_cmd_parser: table of hand-derived byte vectors, reset/gap sequences, then random lines
// checked against a string-level model of which line prefixes can still become a legal command.
module tb_rx_cmd_parser;

    localparam int MAX_LINE = 16;
    localparam logic [4:0] P_INIT  = 5'b10000;
    localparam logic [4:0] P_NORM  = 5'b01000;
    localparam logic [4:0] P_START = 5'b00100;
    localparam logic [4:0] P_RVLD  = 5'b00010;
    localparam logic [4:0] P_ERR   = 5'b00001;
    localparam logic [7:0] B_LF    = 8'h0A;
    localparam logic [7:0] B_CR    = 8'h0D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       o_init, o_norm, o_start, o_rvld, o_err;
    logic [7:0] o_rate;
`ifdef RX_CMD_ECHO_EN
    logic [7:0] o_echo_data;
    logic       o_echo_vld;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] b;
        logic [4:0] pulses;
        logic [7:0] rate;
    } vec_t;
    vec_t vecs[$];

    string      m_line;
    bit         m_errd;
    logic [7:0] m_rate;

    always #5 clk = ~clk;

    rx_cmd_parser #(.MAX_LINE(MAX_LINE)) dut (
        .clk                (clk),
        .reset              (reset),
        .iRX_DATA           (rx_data),
        .iRX_VALID          (rx_valid),
        .oCMD_INITIAL       (o_init),
        .oCMD_NORMAL        (o_norm),
        .oCMD_START_CONTROL (o_start),
        .oRATE              (o_rate),
        .oRATE_VALID        (o_rvld),
        .oCMD_ERR           (o_err)
`ifdef RX_CMD_ECHO_EN
        ,
        .oECHO_DATA         (o_echo_data),
        .oECHO_VALID        (o_echo_vld)
`endif
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [4:0] ep, input logic [7:0] er);
        logic [4:0] got;
        got = {o_init, o_norm, o_start, o_rvld, o_err};
        total++;
        if (got !== ep || o_rate !== er) begin
            bad++;
            $display("FAIL %s: pulses=%b rate=%0d, required pulses=%b rate=%0d", name, got, o_rate, ep, er);
        end
    endtask

    task automatic drive_check(input logic [7:0] b, input logic [4:0] ep, input logic [7:0] er,
                               input string name);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check(name, ep, er);
`ifdef RX_CMD_ECHO_EN
        total++;
        if (o_echo_vld !== 1'b1 || o_echo_data !== b) begin
            bad++;
            $display("FAIL %s echo: vld=%b data=%h, required vld=1 data=%h", name, o_echo_vld, o_echo_data, b);
        end
`endif
    endtask

    task automatic idle_check(input logic [7:0] er, input string name);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk);
        #1;
        check(name, 5'b0, er);
`ifdef RX_CMD_ECHO_EN
        total++;
        if (o_echo_vld !== 1'b0) begin
            bad++;
            $display("FAIL %s echo_vld: got %b, required 0", name, o_echo_vld);
        end
`endif
    endtask

    task automatic add_str(input string s, input int err_at, input logic [4:0] last,
                           input logic [7:0] r0, input logic [7:0] r1);
        for (int i = 0; i < s.len(); i++) begin
            vec_t v;
            v.b      = s[i];
            v.pulses = ((i == err_at) ? P_ERR : 5'b0) | ((i == s.len() - 1) ? last : 5'b0);
            v.rate   = (i == s.len() - 1) ? r1 : r0;
            vecs.push_back(v);
        end
    endtask

    // A legal rate line: "rate:" followed by 1..3 digits whose value is at most 255.
    function automatic bit is_rate(input string q);
        int val;
        if (q.len() < 6 || q.len() > 8) return 0;
        if (q.substr(0, 4) != "rate:") return 0;
        val = 0;
        for (int i = 5; i < q.len(); i++) begin
            if (q[i] < "0" || q[i] > "9") return 0;
            val = val * 10 + (q[i] - "0");
        end
        return (val <= 255);
    endfunction

    function automatic int rate_val(input string q);
        int val;
        val = 0;
        for (int i = 5; i < q.len(); i++) val = val * 10 + (q[i] - "0");
        return val;
    endfunction

    // True while the text seen so far can still be completed into a legal line.
    function automatic bit viable(input string q);
        string kws[4];
        kws = '{"init", "norm", "start", "rate:"};
        if (q.len() > MAX_LINE) return 0;
        for (int k = 0; k < 4; k++) begin
            if (q.len() <= kws[k].len() && kws[k].substr(0, q.len() - 1) == q) return 1;
        end
        return is_rate(q);
    endfunction

    task automatic model_send(input logic [7:0] b);
        logic [4:0] ep;
        string      q;
        ep = 5'b0;
        if (b == B_CR) begin
            ep = 5'b0;
        end else if (b == B_LF) begin
            if (!m_errd && m_line.len() != 0) begin
                if (m_line == "init") ep = P_INIT;
                else if (m_line == "norm") ep = P_NORM;
                else if (m_line == "start") ep = P_START;
                else if (is_rate(m_line)) begin
                    ep     = P_RVLD;
                    m_rate = 8'(rate_val(m_line));
                end else ep = P_ERR;
            end
            m_line = "";
            m_errd = 0;
        end else if (!m_errd) begin
            q = {m_line, $sformatf("%c", b)};
            if (!viable(q)) begin
                ep     = P_ERR;
                m_errd = 1;
            end
            m_line = q;
        end
        drive_check(b, ep, m_rate, "rand");
    endtask

    initial begin
        string a20;
        string sl;
        string kws[4];
        string kw;
        int    kind;
        kws = '{"init", "norm", "start", "rate:"};

        // Reset state
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 5'b0, 8'd0);
`ifdef RX_CMD_ECHO_EN
        total++;
        if (o_echo_data !== 8'hFF || o_echo_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_echo: data=%h vld=%b, required data=ff vld=0", o_echo_data, o_echo_vld);
        end
`endif
        @(negedge clk);
        reset = 1'b1;

        a20 = "";
        for (int i = 0; i < 20; i++) a20 = {a20, "a"};
        a20 = {a20, "\n"};

        add_str("init\n",             -1, P_INIT,  8'd0,   8'd0);
        add_str("rate:200\015\n",     -1, P_RVLD,  8'd0,   8'd200);
        add_str("rate:256\n",          7, 5'b0,    8'd200, 8'd200);
        add_str("nxrm\n",              1, 5'b0,    8'd200, 8'd200);
        add_str("start\n",            -1, P_START, 8'd200, 8'd200);
        add_str("rate:\n",             5, 5'b0,    8'd200, 8'd200);
        add_str(a20,                   0, 5'b0,    8'd200, 8'd200);
        add_str("norm\n",             -1, P_NORM,  8'd200, 8'd200);
        add_str("\n",                 -1, 5'b0,    8'd200, 8'd200);
        add_str("rate:007\n",         -1, P_RVLD,  8'd200, 8'd7);
        add_str("ini\n",               3, 5'b0,    8'd7,   8'd7);
        add_str("rate:1234\n",         8, 5'b0,    8'd7,   8'd7);
        add_str("initx\n",             4, 5'b0,    8'd7,   8'd7);
        add_str("\015start\015\n",    -1, P_START, 8'd7,   8'd7);
        add_str("r\n",                 1, 5'b0,    8'd7,   8'd7);
        add_str("rate:0\n",           -1, P_RVLD,  8'd7,   8'd0);
        add_str("rate:255\n",         -1, P_RVLD,  8'd0,   8'd255);

        foreach (vecs[i]) drive_check(vecs[i].b, vecs[i].pulses, vecs[i].rate, $sformatf("vec%0d", i));
        idle_check(8'd255, "after_table");

        // Strobes separated by idle cycles
        drive_check("i", 5'b0, 8'd255, "gap_i");
        idle_check(8'd255, "gap_idle");
        drive_check("n", 5'b0, 8'd255, "gap_n");
        idle_check(8'd255, "gap_idle");
        drive_check("i", 5'b0, 8'd255, "gap_i2");
        idle_check(8'd255, "gap_idle");
        drive_check("t", 5'b0, 8'd255, "gap_t");
        idle_check(8'd255, "gap_idle");
        drive_check(B_LF, P_INIT, 8'd255, "gap_lf");
        idle_check(8'd255, "gap_pulse_gone");

        // Reset in the middle of "nor"
        drive_check("n", 5'b0, 8'd255, "mid_n");
        drive_check("o", 5'b0, 8'd255, "mid_o");
        drive_check("r", 5'b0, 8'd255, "mid_r");
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", 5'b0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        drive_check("n", 5'b0, 8'd0, "post_n");
        drive_check("o", 5'b0, 8'd0, "post_o");
        drive_check("r", 5'b0, 8'd0, "post_r");
        drive_check("m", 5'b0, 8'd0, "post_m");
        drive_check(B_LF, P_NORM, 8'd0, "post_lf");
        idle_check(8'd0, "post_idle");

        // Random lines against the model
        m_line = "";
        m_errd = 0;
        m_rate = 8'd0;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 5);
            kw   = kws[$urandom_range(0, 3)];
            case (kind)
                0: sl = (kw == "rate:") ? $sformatf("rate:%0d", $urandom_range(0, 255)) : kw;
                1: sl = $sformatf("rate:%03d", $urandom_range(0, 255));
                2: sl = $sformatf("rate:%0d", $urandom_range(0, 1500));
                3: begin
                    sl = kw;
                    sl.putc($urandom_range(0, sl.len() - 1), 8'($urandom_range(97, 122)));
                end
                4: begin
                    sl = "";
                    for (int i = $urandom_range(0, 20); i > 0; i--) begin
                        logic [7:0] g;
                        g = 8'($urandom_range(1, 255));
                        if (g == B_LF) g = "z";
                        sl = {sl, $sformatf("%c", g)};
                    end
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) sl = kw.substr(0, $urandom_range(0, kw.len() - 1));
                    else sl = {kw, $sformatf("%c", 8'($urandom_range(48, 122)))};
                end
            endcase
            for (int i = 0; i < sl.len(); i++) begin
                if ($urandom_range(0, 3) == 0) idle_check(m_rate, "rand_gap");
                if ($urandom_range(0, 7) == 0) model_send(B_CR);
                model_send(sl[i]);
            end
            model_send(B_LF);
        end
        idle_check(m_rate, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
